// File: rtl/ysyx_201979054_axi_read_arbiter_if.sv
// rtl/ysyx_201979054_axi_read_arbiter_if.sv - request/issue bundle between requesters, arbiter and AXI read master
//
// Purpose: groups every non-clock/reset signal of the read arbiter.
// Ports (signals):
//   i_start_icache/dcache/nc : one-cycle read-request pulses
//   i_addr_icache/dcache/nc  : request addresses, held until the requester's done
//   i_r_last                 : last read beat accepted by the AXI master
//   o_start_read             : one-cycle start to the AXI master
//   o_read_addr/o_read_len   : registered address/length of the granted request
//   o_grant                  : one-hot {nc, dcache, icache}
//   o_done_icache/dcache/nc  : done pulse to the winner
//   o_busy                   : transaction in flight
//   o_timeout                : watchdog pulse
// Modports: slave = arbiter view, master = requester/AXI-master side view.
interface ysyx_201979054_axi_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_start_icache;
    logic                  i_start_dcache;
    logic                  i_start_nc;
    logic [ADDR_WIDTH-1:0] i_addr_icache;
    logic [ADDR_WIDTH-1:0] i_addr_dcache;
    logic [ADDR_WIDTH-1:0] i_addr_nc;
    logic                  i_r_last;
    logic                  o_start_read;
    logic [ADDR_WIDTH-1:0] o_read_addr;
    logic [7:0]            o_read_len;
    logic [2:0]            o_grant;
    logic                  o_done_icache;
    logic                  o_done_dcache;
    logic                  o_done_nc;
    logic                  o_busy;
    logic                  o_timeout;

    modport slave (
        input  i_start_icache, i_start_dcache, i_start_nc,
        input  i_addr_icache, i_addr_dcache, i_addr_nc,
        input  i_r_last,
        output o_start_read, o_read_addr, o_read_len, o_grant,
        output o_done_icache, o_done_dcache, o_done_nc,
        output o_busy, o_timeout
    );

    modport master (
        output i_start_icache, i_start_dcache, i_start_nc,
        output i_addr_icache, i_addr_dcache, i_addr_nc,
        output i_r_last,
        input  o_start_read, o_read_addr, o_read_len, o_grant,
        input  o_done_icache, o_done_dcache, o_done_nc,
        input  o_busy, o_timeout
    );
endinterface

// File: rtl/ysyx_201979054_axi_read_arbiter.sv
// rtl/ysyx_201979054_axi_read_arbiter.sv - round-robin arbiter sharing one AXI read master among icache, dcache and nc loads
//
// Purpose: latches start pulses as pending requests, picks one winner by
// round-robin, issues exactly one read at a time and routes r_last back to
// the winner as its done pulse.
// Ports:
//   clk  : clock, rising edge
//   arst : asynchronous active-high reset
//   bus  : ysyx_201979054_axi_read_arbiter_if.slave (requests, issue, done)
// Optional feature: YSYX_201979054_ARB_TIMEOUT_EN enables a BUSY watchdog
// that ends a transaction after TIMEOUT_CYCLES cycles without r_last.
module ysyx_201979054_axi_read_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BLOCK_BEATS    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic arst,
    ysyx_201979054_axi_read_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_e;

    // Requester bit positions: [0]=icache, [1]=dcache, [2]=nc
    localparam logic [2:0] G_IC = 3'b001;
    localparam logic [2:0] G_DC = 3'b010;
    localparam logic [2:0] G_NC = 3'b100;
    localparam logic [7:0] CACHE_LEN = 8'(BLOCK_BEATS - 1);

    state_e                state_q, state_d;
    logic [2:0]            pend_q, pend_d;
    logic [2:0]            last_q, last_d;
    logic [2:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;

    logic [2:0]            start;
    logic [2:0]            req;
    logic [2:0]            win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [2:0]            done;
    logic                  start_read;
    logic                  timeout;

    assign start = {bus.i_start_nc, bus.i_start_dcache, bus.i_start_icache};
    // Same-cycle pulses compete immediately, without waiting for pend.
    assign req   = pend_q | start;

    // Round-robin: search starts just after the previous winner.
    always_comb begin
        win = 3'b000;
        case (last_q)
            G_IC: begin
                if      (req[1]) win = G_DC;
                else if (req[2]) win = G_NC;
                else if (req[0]) win = G_IC;
            end
            G_DC: begin
                if      (req[2]) win = G_NC;
                else if (req[0]) win = G_IC;
                else if (req[1]) win = G_DC;
            end
            default: begin
                if      (req[0]) win = G_IC;
                else if (req[1]) win = G_DC;
                else if (req[2]) win = G_NC;
            end
        endcase
    end

    always_comb begin
        win_addr = bus.i_addr_icache;
        if (win[1]) win_addr = bus.i_addr_dcache;
        if (win[2]) win_addr = bus.i_addr_nc;
    end

`ifdef YSYX_201979054_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    // The first BUSY cycle sees count 0, so firing at TIMEOUT_CYCLES-1
    // lands the pulse TIMEOUT_CYCLES cycles after ISSUE.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ISSUE) cnt_d = '0;
        else if (state_q == S_BUSY) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q | start;
        last_d     = last_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        len_d      = len_q;
        done       = 3'b000;
        start_read = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 3'b000) begin
                    grant_d = win;
                    last_d  = win;
                    addr_d  = win_addr;
                    len_d   = win[2] ? 8'd0 : CACHE_LEN;
                    pend_d  = (pend_q | start) & ~win;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_read = 1'b1;
                state_d    = S_BUSY;
            end
            S_BUSY: begin
                if (bus.i_r_last) begin
                    done    = grant_q;
                    grant_d = 3'b000;
                    state_d = S_IDLE;
                end
`ifdef YSYX_201979054_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    done    = grant_q;
                    grant_d = 3'b000;
                    state_d = S_IDLE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            pend_q  <= 3'b000;
            last_q  <= G_NC;
            grant_q <= 3'b000;
            addr_q  <= '0;
            len_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign bus.o_start_read  = start_read;
    assign bus.o_read_addr   = addr_q;
    assign bus.o_read_len    = len_q;
    assign bus.o_grant       = grant_q;
    assign bus.o_done_icache = done[0];
    assign bus.o_done_dcache = done[1];
    assign bus.o_done_nc     = done[2];
    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_timeout     = timeout;

endmodule

// File: tb/tb_ysyx_201979054_axi_read_arbiter.sv
// tb/tb_ysyx_201979054_axi_read_arbiter.sv - directed self-checking bench for the AXI read arbiter
module tb_ysyx_201979054_axi_read_arbiter;

    localparam logic [31:0] A_IC = 32'h8000_0040;
    localparam logic [31:0] A_DC = 32'h8000_1000;
    localparam logic [31:0] A_NC = 32'h1000_0000;

    logic clk;
    logic arst;
    int   n_checks;
    int   n_fail;

    ysyx_201979054_axi_read_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    ysyx_201979054_axi_read_arbiter #(
        .ADDR_WIDTH    (32),
        .BLOCK_BEATS   (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] done_vec();
        return {bus.o_done_nc, bus.o_done_dcache, bus.o_done_icache};
    endfunction

    // Advance to the next cycle: inputs change 1 time unit after the edge.
    task automatic nxt();
        @(posedge clk);
        #1;
        bus.i_start_icache = 1'b0;
        bus.i_start_dcache = 1'b0;
        bus.i_start_nc     = 1'b0;
        bus.i_r_last       = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        nxt();
        arst = 1'b1;
        nxt();
        nxt();
        arst = 1'b0;
    endtask

    // Called in the ISSUE cycle (already settled). Runs nbusy BUSY cycles
    // (pulsing bpulse each), then r_last, then checks the IDLE cycle.
    task automatic serve(input string tag, input logic [2:0] g, input logic [7:0] len,
                         input logic [31:0] addr, input int nbusy, input logic [2:0] bpulse);
        check({tag, "_start"}, 32'(bus.o_start_read), 32'd1);
        check({tag, "_grant"}, 32'(bus.o_grant), 32'(g));
        check({tag, "_len"},   32'(bus.o_read_len), 32'(len));
        check({tag, "_addr"},  bus.o_read_addr, addr);
        check({tag, "_busy"},  32'(bus.o_busy), 32'd1);
        for (int k = 0; k < nbusy; k++) begin
            nxt();
            bus.i_start_icache = bpulse[0];
            bus.i_start_dcache = bpulse[1];
            bus.i_start_nc     = bpulse[2];
            settle();
            check({tag, "_busy_quiet"}, {28'd0, bus.o_start_read, done_vec()}, 32'd0);
        end
        nxt();
        bus.i_r_last = 1'b1;
        settle();
        check({tag, "_done"}, 32'(done_vec()), 32'(g));
        check({tag, "_grant_hold"}, 32'(bus.o_grant), 32'(g));
        nxt();
        settle();
        check({tag, "_idle"}, {27'd0, bus.o_busy, bus.o_grant, bus.o_start_read}, 32'd0);
        check({tag, "_addr_stable"}, bus.o_read_addr, addr);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        arst     = 1'b1;
        bus.i_start_icache = 1'b0;
        bus.i_start_dcache = 1'b0;
        bus.i_start_nc     = 1'b0;
        bus.i_r_last       = 1'b0;
        bus.i_addr_icache  = A_IC;
        bus.i_addr_dcache  = A_DC;
        bus.i_addr_nc      = A_NC;

        // Reset state
        nxt();
        nxt();
        settle();
        check("rst_outs", {21'd0, bus.o_start_read, bus.o_busy, bus.o_grant, done_vec(),
                           bus.o_timeout}, 32'd0);
        check("rst_addr", bus.o_read_addr, 32'd0);
        check("rst_len",  32'(bus.o_read_len), 32'd0);
        arst = 1'b0;

        // Test 1: single icache pulse, 18 BUSY cycles, then r_last
        nxt();
        bus.i_start_icache = 1'b1;
        settle();
        check("t1_pulse_cycle", {30'd0, bus.o_start_read, bus.o_busy}, 32'd0);
        nxt();
        settle();
        serve("t1_ic", 3'b001, 8'd15, A_IC, 18, 3'b000);

        // Test 2: all three at once from reset -> icache, dcache, nc
        do_reset();
        bus.i_start_icache = 1'b1;
        bus.i_start_dcache = 1'b1;
        bus.i_start_nc     = 1'b1;
        settle();
        check("t2_pulse_cycle", 32'(bus.o_start_read), 32'd0);
        nxt();
        settle();
        serve("t2_ic", 3'b001, 8'd15, A_IC, 3, 3'b000);
        nxt();
        settle();
        serve("t2_dc", 3'b010, 8'd15, A_DC, 2, 3'b000);
        nxt();
        settle();
        serve("t2_nc", 3'b100, 8'd0, A_NC, 1, 3'b000);
        nxt();
        settle();
        check("t2_drained", {30'd0, bus.o_busy, bus.o_start_read}, 32'd0);

        // Test 3: dcache pulsed three times while pending -> one dcache read
        do_reset();
        bus.i_start_icache = 1'b1;
        settle();
        nxt();
        settle();
        serve("t3_ic", 3'b001, 8'd15, A_IC, 3, 3'b010);
        nxt();
        settle();
        serve("t3_dc", 3'b010, 8'd15, A_DC, 2, 3'b000);
        for (int k = 0; k < 3; k++) begin
            nxt();
            settle();
            check("t3_no_reissue", {30'd0, bus.o_busy, bus.o_start_read}, 32'd0);
        end

        // Test 4a: r_last in IDLE is ignored
        nxt();
        bus.i_r_last = 1'b1;
        settle();
        check("t4_idle_rlast_done", 32'(done_vec()), 32'd0);
        check("t4_idle_rlast_busy", 32'(bus.o_busy), 32'd0);

        // Test 4b: arst mid-BUSY with a queued icache request
        nxt();
        bus.i_start_nc = 1'b1;
        settle();
        nxt();
        settle();
        check("t4_nc_issue", 32'(bus.o_grant), 32'b100);
        nxt();
        bus.i_start_icache = 1'b1;
        settle();
        nxt();
        arst = 1'b1;
        bus.i_r_last = 1'b1;
        settle();
        check("t4_rst_outs", {21'd0, bus.o_start_read, bus.o_busy, bus.o_grant, done_vec(),
                              bus.o_timeout}, 32'd0);
        check("t4_rst_addr", bus.o_read_addr, 32'd0);
        check("t4_rst_len",  32'(bus.o_read_len), 32'd0);
        nxt();
        arst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt();
            settle();
            check("t4_pend_cleared", {30'd0, bus.o_busy, bus.o_start_read}, 32'd0);
        end

        // Test 5: watchdog (nc with no r_last, icache waiting)
        do_reset();
        bus.i_start_nc = 1'b1;
        settle();
        nxt();
        settle();
        check("t5_nc_grant", 32'(bus.o_grant), 32'b100);
        check("t5_nc_len",   32'(bus.o_read_len), 32'd0);
`ifdef YSYX_201979054_ARB_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            nxt();
            if (k == 1) bus.i_start_icache = 1'b1;
            settle();
            check("t5_no_timeout", {30'd0, bus.o_timeout, bus.o_done_nc}, 32'd0);
        end
        nxt();
        settle();
        check("t5_timeout", {30'd0, bus.o_timeout, bus.o_done_nc}, 32'b11);
        nxt();
        settle();
        check("t5_idle", {30'd0, bus.o_busy, bus.o_timeout}, 32'd0);
        nxt();
        settle();
        check("t5_ic_issue", {28'd0, bus.o_grant, bus.o_start_read}, {28'd0, 3'b001, 1'b1});
`else
        for (int k = 1; k < 20; k++) begin
            nxt();
            if (k == 1) bus.i_start_icache = 1'b1;
            settle();
            check("t5_wait", {29'd0, bus.o_busy, bus.o_timeout, bus.o_done_nc}, 32'b100);
        end
        nxt();
        bus.i_r_last = 1'b1;
        settle();
        check("t5_nc_done", 32'(done_vec()), 32'b100);
        nxt();
        nxt();
        settle();
        check("t5_ic_issue", {28'd0, bus.o_grant, bus.o_start_read}, {28'd0, 3'b001, 1'b1});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_201979054_axi_read_arbiter.md
# ysyx_201979054_axi_read_arbiter

Shares the single AXI read master between three requesters: the instruction cache FSM, the data cache FSM and the non-cacheable (MMIO/uncached) load path. Start pulses are latched as pending requests, one winner is picked by round-robin, and exactly one read transaction is issued at a time. `r_last` is routed back to the winner only. It sits between the control unit's cache/non-cacheable FSMs and the AXI read master, and replaces the plain OR of cache read starts.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all request and issued addresses.
- BLOCK_BEATS, 16, beats per cache-line burst; issued length for cache requests is BLOCK_BEATS-1.
- TIMEOUT_CYCLES, 1024, watchdog limit in BUSY; only used with the timeout macro.

Ports:
- clk  in  1  single clock; all state on rising edge.
- arst  in  1  reset, asynchronous and active-high.
- i_start_icache / i_start_dcache / i_start_nc  in  1 each  one-cycle read-request pulses.
- i_addr_icache / i_addr_dcache / i_addr_nc  in  ADDR_WIDTH each  request address; sampled in the grant cycle; held by requester until its done.
- i_r_last  in  1  last read beat accepted by the AXI master.
- o_start_read  out  1  one-cycle start to the AXI master.
- o_read_addr  out  ADDR_WIDTH  registered address of the granted request.
- o_read_len  out  8  BLOCK_BEATS-1 for cache grants, 0 for nc.
- o_grant  out  3  one-hot {nc, dcache, icache}; held from ISSUE through BUSY.
- o_done_icache / o_done_dcache / o_done_nc  out  1 each  done pulse to the winner.
- o_busy  out  1  high in ISSUE and BUSY.
- o_timeout  out  1  one-cycle watchdog pulse; tied 0 without the macro.

## Operation
- Pending register pend[2:0]: bit set on its start pulse, cleared on the cycle that requester is granted. A pulse while its bit is already set is absorbed, with no double issue.
- Arbitration input is req = pend | start pulses. A same-cycle pulse is eligible immediately.
- Round-robin: search order begins after last_grant. last_grant resets to nc, so the first order is icache, dcache, nc.
- FSM IDLE -> ISSUE -> BUSY -> IDLE:
  - IDLE: if req != 0, latch winner into o_grant, last_grant, o_read_addr and o_read_len; clear the winner's pend bit; go to ISSUE.
  - ISSUE: o_start_read=1 for exactly this cycle; go to BUSY.
  - BUSY: wait for i_r_last. In that cycle, o_done_<winner>=1 combinationally; next state is IDLE with o_grant cleared.
- i_r_last outside BUSY is ignored, with no done pulse.
- A start pulse from the current winner during ISSUE/BUSY sets its pend bit and is served in a later arbitration.

## Timing
- Reset values: every output 0; state IDLE; pend 0; last_grant = nc; watchdog counter 0.
- Latency: pulse at cycle N in IDLE gives o_start_read at N+1. r_last at cycle M gives done at M, and IDLE at M+1. The earliest next o_start_read is M+2.
- Minimum gap between back-to-back transactions: 1 idle cycle.
- o_read_addr and o_read_len are stable from ISSUE until the next grant.
- arst mid-transaction: immediate return to reset values. The pending request is lost; the requesters and the AXI master share arst.

## Configuration
- YSYX_201979054_ARB_TIMEOUT_EN defined:
  - Counter of $clog2(TIMEOUT_CYCLES)+1 bits clears on ISSUE and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without i_r_last: o_timeout=1 and o_done_<winner>=1 for one cycle, then IDLE.
- Undefined: no counter, o_timeout tied 0, BUSY waits indefinitely.

## Test plan
- Single icache pulse at cycle 5, addr 0x8000_0040; r_last at 25 -> o_start_read at 6, o_read_len=15, o_grant=001, o_done_icache at 25, o_busy low at 26.
- Icache, dcache and nc pulses all at cycle 3 -> grants icache, dcache, nc in that order. Each start is 2 cycles after the previous r_last. nc o_read_len=0.
- Dcache pulse repeated 3 times while dcache pending, plus icache busy -> exactly one dcache transaction issued.
- i_r_last pulsed in IDLE, and arst asserted mid-BUSY -> no done pulses; all outputs 0 in the reset cycle; pend cleared.
- With YSYX_201979054_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, nc grant with no r_last -> o_timeout and o_done_nc together 8 cycles after ISSUE. A pending icache request is then issued 2 cycles later.
